spi_burst_ctrl: RTL

Multi-byte transaction controller that sits directly upstream of the byte-level SPI master. It buffers outgoing bytes in a TX FIFO and frames a burst with a chip select. It feeds the master one byte at a time over the din/start handshake, and collects each received byte (dout on the done tick) into an RX FIFO. Host logic sees only FIFO push/pop, a go strobe, busy and a completion tick.

---
 rtl/spi_burst_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_ctrl.sv
// Burst controller in front of a byte-level SPI master: TX/RX byte FIFOs,
// slave-select framing with setup/hold spacing, one start per byte.
module spi_burst_ctrl #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned CS_SETUP  = 4,
    parameter int unsigned CS_HOLD   = 4,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_wr_i,
    output logic             tx_full_o,
    output logic [7:0]       rx_data_o,
    input  logic             rx_rd_i,
    output logic             rx_empty_o,
    input  logic [LEN_W-1:0] len_i,
    input  logic             go_i,
    output logic             busy_o,
    output logic             done_tick_o,
    output logic             rx_ovf_o,
    output logic             ss_n_o,
    output logic [7:0]       spi_din_o,
    output logic             spi_start_o,
    input  logic [7:0]       spi_dout_i,
    input  logic             spi_done_tick_i
);

    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // TX FIFO
    logic [7:0]       tx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wptr, tx_rptr;
    logic             tx_empty, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_empty  = (tx_wptr == tx_rptr);
    assign tx_full_o = (tx_wptr[ADDR_W] != tx_rptr[ADDR_W]) &&
                       (tx_wptr[ADDR_W-1:0] == tx_rptr[ADDR_W-1:0]);
    assign tx_push   = tx_wr_i && !tx_full_o;
    assign tx_head   = tx_mem[tx_rptr[ADDR_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_W'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr[ADDR_W-1:0]] <= tx_data_i;
    end

    // RX FIFO; a push is judged against the full flag before any same-cycle pop
    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] rx_wptr, rx_rptr;
    logic             rx_full, rx_push_req, rx_push, rx_pop;

    assign rx_empty_o = (rx_wptr == rx_rptr);
    assign rx_full    = (rx_wptr[ADDR_W] != rx_rptr[ADDR_W]) &&
                        (rx_wptr[ADDR_W-1:0] == rx_rptr[ADDR_W-1:0]);
    assign rx_push    = rx_push_req && !rx_full;
    assign rx_pop     = rx_rd_i && !rx_empty_o;
    assign rx_data_o  = rx_mem[rx_rptr[ADDR_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_W'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr[ADDR_W-1:0]] <= spi_dout_i;
    end

    // Burst FSM
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ss_n_d, busy_d, done_d, start_d, ovf_d, enter_load;
    logic [7:0]       din_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cnt_q       <= '0;
            ss_n_o      <= 1'b1;
            busy_o      <= 1'b0;
            done_tick_o <= 1'b0;
            spi_start_o <= 1'b0;
            spi_din_o   <= 8'h00;
            rx_ovf_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            ss_n_o      <= ss_n_d;
            busy_o      <= busy_d;
            done_tick_o <= done_d;
            spi_start_o <= start_d;
            spi_din_o   <= din_d;
            rx_ovf_o    <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        ss_n_d      = ss_n_o;
        busy_d      = busy_o;
        done_d      = 1'b0;
        start_d     = 1'b0;
        din_d       = spi_din_o;
        ovf_d       = rx_ovf_o;
        enter_load  = 1'b0;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;

        case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        ovf_d   = 1'b0;
                        tmr_d   = '0;
                        ss_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    enter_load = 1'b1;
                    state_d    = LOAD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            LOAD: state_d = XFER;
            XFER: begin
                if (spi_done_tick_i) begin
                    rx_push_req = 1'b1;
                    if (rx_full) ovf_d = 1'b1;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q > LEN_W'(1)) begin
                        enter_load = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        tmr_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte hand-off to the master happens on the edge that enters LOAD
        if (enter_load) begin
            start_d = 1'b1;
            tx_pop  = !tx_empty;
            din_d   = tx_empty ? FILL_BYTE : tx_head;
        end
    end

endmodule
